// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage -- writeback stage of the single-issue RV32 core.
//
// Takes one retiring instruction at a time from EXU (valid/ready handshake),
// waits for LSU read data on loads (aligning and sign/zero-extending it),
// then spends exactly one cycle in WRITE driving the register-file write
// port and a commit pulse. A busy mask of pending destination registers is
// kept for the decode-stage hazard check.
//
// Optional build macro: WB_STAGE_TRACE_EN
//   defined   -> $display trace of every WRITE cycle and every error cause
//   undefined -> no display code compiled; behaviour identical
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      EXU handshake
//   in_pc, in_rd, in_wen     retiring instruction PC, rd, write-enable
//   in_data                  ALU result, or effective address for loads
//   in_is_load, in_funct3    load flag and load type (LB/LH/LW/LBU/LHU)
//   lsu_rvalid, lsu_rdata    LSU read-data pulse and aligned 32-bit word
//   rf_wen/waddr/wdata       register-file write port
//   commit_valid, commit_pc  one-cycle retire pulse with PC
//   busy_mask                bit i set while a write to x[i] is pending
//   err                      sticky: misalign, bad funct3 or load timeout
// -----------------------------------------------------------------------------
module wb_stage #(
    parameter int ADDR_WIDTH   = 5,
    parameter int DATA_WIDTH   = 32,
    parameter int LOAD_TIMEOUT = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_pc,
    input  logic [ADDR_WIDTH-1:0] in_rd,
    input  logic                  in_wen,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_is_load,
    input  logic [2:0]            in_funct3,
    input  logic                  lsu_rvalid,
    input  logic [31:0]           lsu_rdata,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  commit_valid,
    output logic [31:0]           commit_pc,
    output logic [31:0]           busy_mask,
    output logic                  err
);

    localparam int CNT_W = $clog2(LOAD_TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_MEM = 2'd1,
        S_WRITE    = 2'd2
    } state_t;

    // Error cause codes (only consumed by the trace build).
    localparam logic [1:0] CAUSE_NONE     = 2'd0;
    localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
    localparam logic [1:0] CAUSE_FUNCT3   = 2'd2;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'd3;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [31:0]           r_pc;
    logic [ADDR_WIDTH-1:0] r_rd;
    logic                  r_wen;
    logic [2:0]            r_f3;
    logic [1:0]            r_alo;

    logic                  r_rf_wen;
    logic [ADDR_WIDTH-1:0] r_rf_waddr;
    logic [DATA_WIDTH-1:0] r_rf_wdata;
    logic                  r_commit_valid;
    logic [31:0]           r_commit_pc;
    logic [31:0]           r_busy;
    logic                  r_err;

    state_t                w_state_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic                  w_accept;
    logic                  w_go_write;
    logic [31:0]           w_wr_pc;
    logic [ADDR_WIDTH-1:0] w_wr_rd;
    logic                  w_wr_wen;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic                  w_err_set;
    logic [1:0]            w_err_cause;
    logic [31:0]           w_busy_nxt;

    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [DATA_WIDTH-1:0] w_ext;
    logic [1:0]            w_ext_cause;

    assign w_accept = in_valid && (r_state != S_WAIT_MEM);

    // Load data extraction from the latched funct3 / address offset.
    always_comb begin
        w_ext       = '0;
        w_ext_cause = CAUSE_NONE;
        case (r_alo)
            2'd0:    w_byte = lsu_rdata[7:0];
            2'd1:    w_byte = lsu_rdata[15:8];
            2'd2:    w_byte = lsu_rdata[23:16];
            default: w_byte = lsu_rdata[31:24];
        endcase
        w_half = r_alo[1] ? lsu_rdata[31:16] : lsu_rdata[15:0];
        case (r_f3)
            3'd0: w_ext = DATA_WIDTH'($signed(w_byte));
            3'd4: w_ext = DATA_WIDTH'(w_byte);
            3'd1: begin
                if (r_alo[0]) w_ext_cause = CAUSE_MISALIGN;
                else          w_ext = DATA_WIDTH'($signed(w_half));
            end
            3'd5: begin
                if (r_alo[0]) w_ext_cause = CAUSE_MISALIGN;
                else          w_ext = DATA_WIDTH'(w_half);
            end
            3'd2: begin
                if (r_alo != 2'd0) w_ext_cause = CAUSE_MISALIGN;
                else               w_ext = DATA_WIDTH'(lsu_rdata);
            end
            default: w_ext_cause = CAUSE_FUNCT3;
        endcase
    end

    // Next state and the values that will be presented during WRITE.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_go_write  = 1'b0;
        w_wr_pc     = r_pc;
        w_wr_rd     = r_rd;
        w_wr_wen    = r_wen;
        w_wr_data   = '0;
        w_err_set   = 1'b0;
        w_err_cause = CAUSE_NONE;
        case (r_state)
            S_WAIT_MEM: begin
                if (lsu_rvalid) begin
                    w_state_nxt = S_WRITE;
                    w_go_write  = 1'b1;
                    w_wr_data   = w_ext;
                    w_err_cause = w_ext_cause;
                    w_err_set   = (w_ext_cause != CAUSE_NONE);
                end else if (r_cnt == CNT_W'(LOAD_TIMEOUT - 1)) begin
                    w_state_nxt = S_WRITE;
                    w_go_write  = 1'b1;
                    w_err_set   = 1'b1;
                    w_err_cause = CAUSE_TIMEOUT;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                // IDLE and WRITE both accept; WRITE falls back to IDLE if idle.
                if (w_accept) begin
                    if (in_is_load) begin
                        w_state_nxt = S_WAIT_MEM;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = S_WRITE;
                        w_go_write  = 1'b1;
                        w_wr_pc     = in_pc;
                        w_wr_rd     = in_rd;
                        w_wr_wen    = in_wen;
                        w_wr_data   = in_data;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
        endcase
    end

    // Clear the retiring register first so a same-edge set wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_state == S_WRITE && r_rf_wen)
            w_busy_nxt[r_rf_waddr] = 1'b0;
        if (w_accept && in_wen && in_rd != '0)
            w_busy_nxt[in_rd] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_rf_wen       <= 1'b0;
            r_rf_waddr     <= '0;
            r_rf_wdata     <= '0;
            r_commit_valid <= 1'b0;
            r_commit_pc    <= '0;
            r_busy         <= '0;
            r_err          <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_rf_wen       <= w_go_write && w_wr_wen && (w_wr_rd != '0);
            r_commit_valid <= w_go_write;
            if (w_go_write) begin
                r_rf_waddr  <= w_wr_rd;
                r_rf_wdata  <= w_wr_data;
                r_commit_pc <= w_wr_pc;
            end
            r_busy <= w_busy_nxt;
            r_err  <= r_err | w_err_set;
        end
    end

    // Instruction fields; no reset needed, they are only read after an accept.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_pc  <= in_pc;
            r_rd  <= in_rd;
            r_wen <= in_wen;
            r_f3  <= in_funct3;
            r_alo <= in_data[1:0];
        end
    end

    assign in_ready     = (r_state != S_WAIT_MEM);
    assign rf_wen       = r_rf_wen;
    assign rf_waddr     = r_rf_waddr;
    assign rf_wdata     = r_rf_wdata;
    assign commit_valid = r_commit_valid;
    assign commit_pc    = r_commit_pc;
    assign busy_mask    = r_busy;
    assign err          = r_err;

`ifdef WB_STAGE_TRACE_EN
    always @(posedge clk) begin
        if (!rst && r_state == S_WRITE)
            $display("[%0t] wb commit pc=%08h rd=%0d wdata=%08h rf_write=%0d",
                     $time, r_commit_pc, r_rf_waddr, r_rf_wdata, r_rf_wen);
        if (!rst && w_err_set) begin
            case (w_err_cause)
                CAUSE_MISALIGN: $display("[%0t] wb err: misaligned load", $time);
                CAUSE_FUNCT3:   $display("[%0t] wb err: bad load funct3", $time);
                default:        $display("[%0t] wb err: load timeout", $time);
            endcase
        end
    end
`else
    // Trace disabled: nothing extra is built.
`endif

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int LT = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_pc;
    logic [AW-1:0] in_rd;
    logic          in_wen;
    logic [DW-1:0] in_data;
    logic          in_is_load;
    logic [2:0]    in_funct3;
    logic          lsu_rvalid;
    logic [31:0]   lsu_rdata;
    logic          rf_wen;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          commit_valid;
    logic [31:0]   commit_pc;
    logic [31:0]   busy_mask;
    logic          err;

    int n_cmp = 0;
    int n_bad = 0;

    wb_stage #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LOAD_TIMEOUT(LT)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc        (in_pc),
        .in_rd        (in_rd),
        .in_wen       (in_wen),
        .in_data      (in_data),
        .in_is_load   (in_is_load),
        .in_funct3    (in_funct3),
        .lsu_rvalid   (lsu_rvalid),
        .lsu_rdata    (lsu_rdata),
        .rf_wen       (rf_wen),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .commit_valid (commit_valid),
        .commit_pc    (commit_pc),
        .busy_mask    (busy_mask),
        .err          (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Load with rvalid three cycles after the accept edge.
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] exp, input logic exp_err);
        in_valid   = 1'b1;
        in_is_load = 1'b1;
        in_funct3  = f3;
        in_data    = addr;
        in_rd      = 5'd10;
        in_wen     = 1'b1;
        in_pc      = 32'h8000_0100;
        tick();
        in_valid   = 1'b0;
        in_is_load = 1'b0;
        chk({tag, "_ready_wait"}, 32'(in_ready), 32'd0);
        chk({tag, "_busy_wait"}, busy_mask, 32'h0000_0400);
        tick();
        tick();
        chk({tag, "_nowrite_yet"}, 32'(rf_wen), 32'd0);
        lsu_rvalid = 1'b1;
        lsu_rdata  = 32'h8081_F2F3;
        tick();
        lsu_rvalid = 1'b0;
        chk({tag, "_wen"}, 32'(rf_wen), 32'd1);
        chk({tag, "_commit"}, 32'(commit_valid), 32'd1);
        chk({tag, "_waddr"}, 32'(rf_waddr), 32'd10);
        chk({tag, "_wdata"}, rf_wdata, exp);
        chk({tag, "_err"}, 32'(err), 32'(exp_err));
        tick();
        chk({tag, "_busy_after"}, busy_mask, 32'd0);
        chk({tag, "_commit_after"}, 32'(commit_valid), 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b1;
        in_pc      = '0;
        in_rd      = '0;
        in_wen     = 1'b0;
        in_data    = '0;
        in_is_load = 1'b0;
        in_funct3  = '0;
        lsu_rvalid = 1'b0;
        lsu_rdata  = '0;

        // Reset held two edges with in_valid high.
        tick();
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_wen", 32'(rf_wen), 32'd0);
        chk("rst_waddr", 32'(rf_waddr), 32'd0);
        chk("rst_wdata", rf_wdata, 32'd0);
        chk("rst_commit", 32'(commit_valid), 32'd0);
        chk("rst_pc", commit_pc, 32'd0);
        chk("rst_busy", busy_mask, 32'd0);
        chk("rst_err", 32'(err), 32'd0);

        // Single non-load.
        in_valid = 1'b1;
        in_pc    = 32'h8000_0000;
        in_rd    = 5'd5;
        in_data  = 32'h0000_1234;
        in_wen   = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("nl_busy", busy_mask, 32'h0000_0020);
        chk("nl_wen", 32'(rf_wen), 32'd1);
        chk("nl_waddr", 32'(rf_waddr), 32'd5);
        chk("nl_wdata", rf_wdata, 32'h0000_1234);
        chk("nl_commit", 32'(commit_valid), 32'd1);
        chk("nl_pc", commit_pc, 32'h8000_0000);
        tick();
        chk("nl_busy_clr", busy_mask, 32'd0);
        chk("nl_wen_off", 32'(rf_wen), 32'd0);
        chk("nl_commit_off", 32'(commit_valid), 32'd0);
        chk("nl_waddr_hold", 32'(rf_waddr), 32'd5);
        chk("nl_wdata_hold", rf_wdata, 32'h0000_1234);

        // Back-to-back rd=3, rd=3, then rd=0.
        in_valid = 1'b1;
        in_rd    = 5'd3;
        in_pc    = 32'h8000_0004;
        in_data  = 32'h0000_0011;
        tick();
        chk("b2b1_wen", 32'(rf_wen), 32'd1);
        chk("b2b1_wdata", rf_wdata, 32'h0000_0011);
        chk("b2b1_busy", busy_mask, 32'h0000_0008);
        chk("b2b1_ready", 32'(in_ready), 32'd1);
        in_pc   = 32'h8000_0008;
        in_data = 32'h0000_0022;
        tick();
        chk("b2b2_wen", 32'(rf_wen), 32'd1);
        chk("b2b2_wdata", rf_wdata, 32'h0000_0022);
        chk("b2b2_pc", commit_pc, 32'h8000_0008);
        chk("b2b2_busy", busy_mask, 32'h0000_0008);
        in_rd   = 5'd0;
        in_pc   = 32'h8000_000C;
        in_data = 32'h0000_0033;
        tick();
        in_valid = 1'b0;
        chk("x0_commit", 32'(commit_valid), 32'd1);
        chk("x0_wen", 32'(rf_wen), 32'd0);
        chk("x0_pc", commit_pc, 32'h8000_000C);
        chk("x0_busy", busy_mask, 32'd0);
        tick();
        chk("x0_commit_off", 32'(commit_valid), 32'd0);

        // Loads from word 0x8081F2F3.
        do_load("lb3", 3'd0, 32'h0000_1003, 32'hFFFF_FF80, 1'b0);
        do_load("lbu1", 3'd4, 32'h0000_1001, 32'h0000_00F2, 1'b0);
        do_load("lh2", 3'd1, 32'h0000_1002, 32'hFFFF_8081, 1'b0);
        do_load("lw0", 3'd2, 32'h0000_1000, 32'h8081_F2F3, 1'b0);
        do_load("lwmis", 3'd2, 32'h0000_1002, 32'h0000_0000, 1'b1);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("err_clr_rst", 32'(err), 32'd0);
        do_load("badf3", 3'd3, 32'h0000_1000, 32'h0000_0000, 1'b1);

        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Timeout: no rvalid ever.
        in_valid   = 1'b1;
        in_is_load = 1'b1;
        in_funct3  = 3'd2;
        in_data    = 32'h0000_2000;
        in_rd      = 5'd10;
        in_wen     = 1'b1;
        in_pc      = 32'h8000_0200;
        tick();
        in_valid   = 1'b0;
        in_is_load = 1'b0;
        for (int i = 0; i < LT - 1; i++) tick();
        chk("to_early_wen", 32'(rf_wen), 32'd0);
        chk("to_early_ready", 32'(in_ready), 32'd0);
        chk("to_early_err", 32'(err), 32'd0);
        tick();
        chk("to_wen", 32'(rf_wen), 32'd1);
        chk("to_wdata", rf_wdata, 32'd0);
        chk("to_err", 32'(err), 32'd1);
        chk("to_pc", commit_pc, 32'h8000_0200);
        tick();

        // Stray rvalid in IDLE.
        lsu_rvalid = 1'b1;
        tick();
        lsu_rvalid = 1'b0;
        chk("stray_commit", 32'(commit_valid), 32'd0);
        chk("stray_wen", 32'(rf_wen), 32'd0);
        chk("stray_ready", 32'(in_ready), 32'd1);

        // Reset while waiting on a load.
        in_valid   = 1'b1;
        in_is_load = 1'b1;
        in_funct3  = 3'd2;
        in_data    = 32'h0000_3000;
        in_rd      = 5'd7;
        tick();
        in_valid   = 1'b0;
        in_is_load = 1'b0;
        chk("ml_busy", busy_mask, 32'h0000_0080);
        rst = 1'b1;
        tick();
        rst        = 1'b0;
        lsu_rvalid = 1'b1;
        tick();
        lsu_rvalid = 1'b0;
        chk("ml_wen", 32'(rf_wen), 32'd0);
        chk("ml_commit", 32'(commit_valid), 32'd0);
        chk("ml_busy_clr", busy_mask, 32'd0);
        chk("ml_ready", 32'(in_ready), 32'd1);
        tick();
        chk("ml_commit_late", 32'(commit_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
